piso_tx_ctrl: RTL and testbench

//   Frame sequencer for an N-bit parallel-in/serial-out shift datapath (held internally).
//   - Accepts a parallel word over a valid/ready handshake, loads it, and emits it LSB-first.
//   - Frame format: start bit (0), N data bits, optional parity bit, stop bit (1).
//   - Each bit is held for CLKS_PER_BIT clocks.
//   - Sits between a word producer (FIFO/CPU port) and a single-wire serial line.

---
 rtl/piso_tx_ctrl.sv | 152 +++++++++++++++
 tb/tb_piso_tx_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/piso_tx_ctrl.sv
// Frame sequencer for an N-bit parallel-in/serial-out line: start(0), N data bits LSB-first,
// optional parity, stop(1); each bit held CLKS_PER_BIT clocks. Parity enabled by PISO_PARITY_EN.
module piso_tx_ctrl #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         ser_out,
  output logic         busy,
  output logic         done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(N);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  if (N < 2 || CLKS_PER_BIT < 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("piso_tx_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PISO_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   shift_q, shift_d;
  logic           ser_q, ser_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           bnd;
`ifdef PISO_PARITY_EN
  logic           par_q, par_d;
`endif

  assign in_ready = (state_q == IDLE);
  assign ser_out  = ser_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bnd      = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ser_d   = ser_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) baud_d = bnd ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: begin
        ser_d = 1'b1;
        if (in_valid) begin
          shift_d = in_data;
          state_d = START;
          ser_d   = 1'b0;
          baud_d  = '0;
          idx_d   = '0;
`ifdef PISO_PARITY_EN
          par_d   = (^in_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (bnd) begin
          state_d = DATA;
          ser_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bnd) begin
          if (idx_q == IDX_LAST) begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
            ser_d   = par_q;
`else
            state_d = STOP;
            ser_d   = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            ser_d   = shift_q[1];
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (bnd) begin
          state_d = STOP;
          ser_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bnd) begin
          state_d = IDLE;
          ser_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ser_d   = 1'b1;
      end
    endcase
    // Flags are registered, so derive them from where the FSM will be next clock.
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Randomized self-checking bench for piso_tx_ctrl: frames are compared clock by clock
// against a bit-list model of the serial frame built from the accepted word.
module tb_piso_tx_ctrl;

  localparam int N   = 8;
  localparam int CPB = 4;
`ifdef PISO_PARITY_EN
  localparam int NB  = N + 3;
`else
  localparam int NB  = N + 2;
`endif
  localparam int FL  = NB * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data, b_data;
  logic       in_valid, b_valid;
  logic       in_ready, ser_out, busy, done;
  logic       b_ready, b_ser, b_busy, b_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc = -1;

  piso_tx_ctrl #(.N(N), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .busy(busy), .done(done)
  );

  piso_tx_ctrl #(.N(N), .CLKS_PER_BIT(1), .PARITY_ODD(1)) u_dut_cpb1 (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .ser_out(b_ser), .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame model: bit i of the serial frame for word w.
  function automatic logic frame_bit(input logic [7:0] w, input int i, input int podd);
    logic q[$];
    q.push_back(1'b0);
    for (int b = 0; b < N; b++) q.push_back(w[b]);
`ifdef PISO_PARITY_EN
    q.push_back(logic'((^w) ^ (podd != 0)));
`endif
    q.push_back(1'b1);
    return q[i];
  endfunction

  // Present w, wait for accept, then check every clock of the frame and the gap clock.
  // abort_k >= 0 asserts reset in that frame clock instead of finishing the frame.
  task automatic tx_frame(input logic [7:0] w, input bit scramble, input bit hold,
                          input logic [7:0] next_w, input int abort_k, input int exp_gap);
    int wt = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && wt < 200) begin
      @(negedge clk);
      wt++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(wt), 32'(0));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (exp_gap > 0) chk("acc_period", 32'(cyc - last_acc), 32'(exp_gap));
    last_acc = cyc;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      chk($sformatf("ser k%0d", k), 32'(ser_out), 32'(frame_bit(w, k / CPB, 0)));
      chk("busy", 32'(busy), 32'(1));
      chk("ready_low", 32'(in_ready), 32'(0));
      chk($sformatf("done k%0d", k), 32'(done), 32'(k == FL - 1));
      if (k == abort_k) begin
        reset = 1'b1;
        #1;
        chk("abort_ser", 32'(ser_out), 32'(1));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ready", 32'(in_ready), 32'(1));
        return;
      end
      if (scramble) begin
        in_data  = 8'($urandom);
        in_valid = 1'($urandom);
      end else if (!hold) begin
        in_valid = 1'b0;
      end
      if (k == FL - 1) begin
        in_valid = hold;
        in_data  = next_w;
      end
    end
    @(negedge clk);
    chk("gap_ser", 32'(ser_out), 32'(1));
    chk("gap_busy", 32'(busy), 32'(0));
    chk("gap_done", 32'(done), 32'(0));
    chk("gap_ready", 32'(in_ready), 32'(1));
  endtask

  initial begin
    logic [7:0] w, nw;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    b_valid  = 1'b0;
    b_data   = 8'h00;
    #1;
    chk("rst_ser", 32'(ser_out), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'(1));
    chk("rst_ser_rel", 32'(ser_out), 32'(1));

    // Single frame, then back-to-back 0x00 -> 0xFF with valid held high.
    tx_frame(8'hA5, 1'b0, 1'b0, 8'h00, -1, 0);
    tx_frame(8'h00, 1'b0, 1'b1, 8'hFF, -1, 0);
    tx_frame(8'hFF, 1'b0, 1'b0, 8'h00, -1, FL + 1);

    // Reset during DATA bit 3, then a clean frame.
    tx_frame(8'h3C, 1'b0, 1'b0, 8'h00, 4 * CPB + 1, 0);
    tx_frame(8'h55, 1'b0, 1'b0, 8'h00, -1, 0);

    // Inputs scrambled while busy.
    tx_frame(8'h96, 1'b1, 1'b0, 8'h00, -1, 0);

    // Random words, random scramble and back-to-back chaining.
    w = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      bit sc, hd;
      sc = 1'($urandom);
      hd = 1'($urandom);
      nw = 8'($urandom);
      tx_frame(w, sc, hd, nw, -1, 0);
      w = hd ? nw : 8'($urandom);
    end

    // CLKS_PER_BIT = 1 instance.
    begin
      int wt = 0;
      b_data  = 8'h81;
      b_valid = 1'b1;
      while (!b_ready && wt < 50) begin
        @(negedge clk);
        wt++;
      end
      chk("b_ready", 32'(b_ready), 32'(1));
      @(posedge clk);
      for (int k = 0; k < NB; k++) begin
        @(negedge clk);
        b_valid = 1'b0;
        b_data  = 8'($urandom);
        chk($sformatf("b_ser k%0d", k), 32'(b_ser), 32'(frame_bit(8'h81, k, 1)));
        chk($sformatf("b_done k%0d", k), 32'(b_done), 32'(k == NB - 1));
        chk("b_busy", 32'(b_busy), 32'(1));
      end
      @(negedge clk);
      chk("b_gap_ser", 32'(b_ser), 32'(1));
      chk("b_gap_busy", 32'(b_busy), 32'(0));
      chk("b_gap_ready", 32'(b_ready), 32'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
